snn_lif_tile_engine: RTL and testbench

//  Event-driven leaky-integrate-and-fire (LIF) engine for one tile of LANES neurons.
//  - Reads membrane potentials and bias for the tile.
//  - Scans input-spike SRAM words. For each set spike bit, fetches one weight row
//    and adds it to all lanes in parallel.
//  - Applies the threshold, fires, resets the potential, then writes back potentials and spikes.
//  - Generalises the fixed 1024-accumulator array: lane count, widths and input count are

---
 rtl/snn_lif_tile_engine_pkg.sv | 34 +++
 rtl/snn_lif_tile_engine_lane.sv | 73 +++++++
 rtl/snn_lif_tile_engine.sv | 187 ++++++++++++++++++
 tb/tb_snn_lif_tile_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_lif_tile_engine_pkg.sv
// Shared types for the LIF tile engine: FSM states, per-lane operation codes
// and the lane slice macro used when splitting packed row buses.
`define SNN_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package snn_lif_tile_engine_pkg;

    localparam int LANES_DEF  = 16;
    localparam int W_W_DEF    = 8;
    localparam int U_W_DEF    = 16;
    localparam int IN_W_DEF   = 16;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEAK,
        ST_INIT,
        ST_FETCH,
        ST_SCAN,
        ST_ACC,
        ST_FIRE,
        ST_WB
    } state_e;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INIT,
        OP_RAW,
        OP_LEAK,
        OP_ADD,
        OP_FIRE
    } lane_op_e;

endpackage

// File: rtl/snn_lif_tile_engine_lane.sv
// One LIF neuron lane: holds its membrane potential and spike flag and applies
// the load / leak / accumulate / fire operation selected by the tile FSM.
module snn_lif_lane
    import snn_lif_tile_engine_pkg::*;
#(
    parameter int W_W        = 8,
    parameter int U_W        = 16,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  lane_op_e              op_i,
    input  logic signed [U_W-1:0] u_rdata_i,
    input  logic signed [W_W-1:0] b_i,
    input  logic signed [W_W-1:0] w_i,
    input  logic signed [U_W-1:0] thresh_i,
    output logic signed [U_W-1:0] u_o,
    output logic                  spike_o
);

    localparam logic signed [U_W-1:0] U_MAX = {1'b0, {(U_W-1){1'b1}}};
    localparam logic signed [U_W-1:0] U_MIN = {1'b1, {(U_W-1){1'b0}}};

    logic signed [U_W-1:0] u_q, u_d;
    logic                  spike_q, spike_d;

    function automatic logic signed [U_W-1:0] sext(input logic signed [W_W-1:0] v);
        return {{(U_W-W_W){v[W_W-1]}}, v};
    endfunction

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    function automatic logic signed [U_W-1:0] sat_add(input logic signed [U_W-1:0] a,
                                                      input logic signed [U_W-1:0] b);
        logic [U_W:0] s;
        s = {a[U_W-1], a} + {b[U_W-1], b};
        return (s[U_W] != s[U_W-1]) ? (s[U_W] ? U_MIN : U_MAX) : s[U_W-1:0];
    endfunction

    // Next-state potential and spike for the requested operation.
    always_comb begin
        u_d     = u_q;
        spike_d = spike_q;
        case (op_i)
            OP_INIT: u_d = sat_add(u_rdata_i, sext(b_i));
            OP_RAW:  u_d = u_rdata_i;
            OP_LEAK: u_d = sat_add(u_q - (u_q >>> LEAK_SHIFT), sext(b_i));
            OP_ADD:  u_d = sat_add(u_q, sext(w_i));
            OP_FIRE: begin
                spike_d = (u_q >= thresh_i);
                u_d     = spike_d ? '0 : u_q;
            end
            default: begin
                u_d     = u_q;
                spike_d = spike_q;
            end
        endcase
    end

    // Lane state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            u_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            u_q     <= u_d;
            spike_q <= spike_d;
        end
    end

    assign u_o     = u_q;
    assign spike_o = spike_q;

endmodule

// File: rtl/snn_lif_tile_engine.sv
// Event-driven LIF tile engine: loads potentials+bias, accumulates one weight row
// per set input-spike bit, fires and writes back. SNN_LEAK_EN adds a leak step.
module snn_lif_tile_engine
    import snn_lif_tile_engine_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int U_W        = U_W_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     tile_sel_i,
    input  logic [ADDR_W-1:0]     w_row_base_i,
    input  logic [ADDR_W+3:0]     cfg_n_in_i,
    input  logic [U_W-1:0]        cfg_thresh_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_W-1:0]     in_spk_addr_o,
    input  logic [IN_W-1:0]       in_spk_rdata_i,
    output logic [ADDR_W-1:0]     w_addr_o,
    input  logic [LANES*W_W-1:0]  w_rdata_i,
    output logic [ADDR_W-1:0]     b_addr_o,
    input  logic [LANES*W_W-1:0]  b_rdata_i,
    output logic [ADDR_W-1:0]     u_addr_o,
    input  logic [LANES*U_W-1:0]  u_rdata_i,
    output logic [LANES*U_W-1:0]  u_wdata_o,
    output logic                  u_we_o,
    output logic [ADDR_W-1:0]     spk_addr_o,
    output logic [LANES-1:0]      spk_wdata_o,
    output logic                  spk_we_o
);

    localparam int IN_LG = $clog2(IN_W);
    localparam int CNT_W = ADDR_W + 4;
    localparam int IDX_W = ADDR_W + IN_LG + 1;

    state_e            state_q;
    logic              busy_q, done_q, we_q, first_q;
    logic [ADDR_W-1:0] tile_q, base_q, word_q;
    logic [CNT_W-1:0]  n_in_q;
    logic [U_W-1:0]    thresh_q;
    logic [IN_W-1:0]   hold_q;

    logic [IN_W-1:0]   cur_s, masked_s;
    logic              found_s, last_s;
    logic [IN_LG-1:0]  bit_s;
    logic [IDX_W-1:0]  n_in_ext_s, next_base_s;
    lane_op_e          op_s;

    // Mask out-of-range inputs and pick the lowest pending spike bit.
    always_comb begin
        cur_s       = first_q ? in_spk_rdata_i : hold_q;
        n_in_ext_s  = IDX_W'(n_in_q);
        masked_s    = '0;
        found_s     = 1'b0;
        bit_s       = '0;
        for (int i = 0; i < IN_W; i++) begin
            masked_s[i] = cur_s[i] && ({1'b0, word_q, IN_LG'(i)} < n_in_ext_s);
        end
        for (int i = IN_W - 1; i >= 0; i--) begin
            bit_s   = masked_s[i] ? IN_LG'(i) : bit_s;
            found_s = found_s | masked_s[i];
        end
        next_base_s = {1'b0, word_q, {IN_LG{1'b0}}} + IDX_W'(IN_W);
        last_s      = (next_base_s >= n_in_ext_s);
    end

    // Lane operation for the current state.
    always_comb begin
        op_s = OP_HOLD;
        case (state_q)
`ifdef SNN_LEAK_EN
            ST_INIT: op_s = OP_LEAK;
`else
            ST_INIT: op_s = OP_INIT;
`endif
            ST_LEAK: op_s = OP_RAW;
            ST_ACC:  op_s = OP_ADD;
            ST_FIRE: op_s = OP_FIRE;
            default: op_s = OP_HOLD;
        endcase
    end

    // Control FSM; configuration is captured once at start acceptance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            first_q  <= 1'b0;
            tile_q   <= '0;
            base_q   <= '0;
            word_q   <= '0;
            n_in_q   <= '0;
            thresh_q <= '0;
            hold_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tile_q   <= tile_sel_i;
                        base_q   <= w_row_base_i;
                        n_in_q   <= cfg_n_in_i;
                        thresh_q <= cfg_thresh_i;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
`ifdef SNN_LEAK_EN
                ST_LOAD:  state_q <= ST_LEAK;
`else
                ST_LOAD:  state_q <= ST_INIT;
`endif
                ST_LEAK:  state_q <= ST_INIT;
                ST_INIT: begin
                    word_q  <= '0;
                    state_q <= (n_in_q == '0) ? ST_FIRE : ST_FETCH;
                end
                ST_FETCH: begin
                    first_q <= 1'b1;
                    state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    first_q <= 1'b0;
                    if (found_s) begin
                        hold_q  <= masked_s & ~(IN_W'(1) << bit_s);
                        state_q <= ST_ACC;
                    end else if (last_s) begin
                        state_q <= ST_FIRE;
                    end else begin
                        word_q  <= word_q + ADDR_W'(1);
                        state_q <= ST_FETCH;
                    end
                end
                ST_ACC:   state_q <= ST_SCAN;
                ST_FIRE: begin
                    we_q    <= 1'b1;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The weight address must be valid in SCAN so the row arrives for ACC.
    assign w_addr_o      = (state_q == ST_SCAN && found_s) ?
                           base_q + ADDR_W'({word_q, bit_s}) : '0;
    assign in_spk_addr_o = word_q;
    assign b_addr_o      = tile_q;
    assign u_addr_o      = tile_q;
    assign spk_addr_o    = tile_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign u_we_o        = we_q;
    assign spk_we_o      = we_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        snn_lif_lane #(
            .W_W        (W_W),
            .U_W        (U_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .op_i      (op_s),
            .u_rdata_i (`SNN_SLICE(u_rdata_i, k, U_W)),
            .b_i       (`SNN_SLICE(b_rdata_i, k, W_W)),
            .w_i       (`SNN_SLICE(w_rdata_i, k, W_W)),
            .thresh_i  (thresh_q),
            .u_o       (`SNN_SLICE(u_wdata_o, k, U_W)),
            .spike_o   (spk_wdata_o[k])
        );
    end

endmodule

// File: tb/tb_snn_lif_tile_engine.sv
// Scoreboard bench for snn_lif_tile_engine: directed cases push expected writebacks,
// a monitor compares them when u_we/done appear.
module tb_snn_lif_tile_engine;

    localparam int LANES  = 16;
    localparam int W_W    = 8;
    localparam int U_W    = 16;
    localparam int IN_W   = 16;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = ADDR_W + 4;
    localparam int LW     = LANES * U_W;
    localparam int BW     = LANES * W_W;
`ifdef SNN_LEAK_EN
    localparam int LEAK_CYC = 1;
`else
    localparam int LEAK_CYC = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] tile_sel = '0, w_row_base = '0;
    logic [CNT_W-1:0]  cfg_n_in = '0;
    logic [U_W-1:0]    cfg_thresh = '0;
    logic              busy_o, done_o, u_we_o, spk_we_o;
    logic [ADDR_W-1:0] in_spk_addr_o, w_addr_o, b_addr_o, u_addr_o, spk_addr_o;
    logic [IN_W-1:0]   in_spk_rdata;
    logic [BW-1:0]     w_rdata, b_rdata;
    logic [LW-1:0]     u_rdata, u_wdata_o;
    logic [LANES-1:0]  spk_wdata_o;

    logic [LW-1:0]   u_mem [2**ADDR_W];
    logic [BW-1:0]   b_mem [2**ADDR_W];
    logic [BW-1:0]   w_mem [2**ADDR_W];
    logic [IN_W-1:0] s_mem [2**ADDR_W];

    typedef struct {
        string             nm;
        logic [LW-1:0]     u;
        logic [LANES-1:0]  s;
        logic [ADDR_W-1:0] tile;
        int                lat;
        int                t0;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    snn_lif_tile_engine dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .start_i        (start),
        .tile_sel_i     (tile_sel),
        .w_row_base_i   (w_row_base),
        .cfg_n_in_i     (cfg_n_in),
        .cfg_thresh_i   (cfg_thresh),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .in_spk_addr_o  (in_spk_addr_o),
        .in_spk_rdata_i (in_spk_rdata),
        .w_addr_o       (w_addr_o),
        .w_rdata_i      (w_rdata),
        .b_addr_o       (b_addr_o),
        .b_rdata_i      (b_rdata),
        .u_addr_o       (u_addr_o),
        .u_rdata_i      (u_rdata),
        .u_wdata_o      (u_wdata_o),
        .u_we_o         (u_we_o),
        .spk_addr_o     (spk_addr_o),
        .spk_wdata_o    (spk_wdata_o),
        .spk_we_o       (spk_we_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        u_rdata      <= u_mem[u_addr_o];
        b_rdata      <= b_mem[b_addr_o];
        w_rdata      <= w_mem[w_addr_o];
        in_spk_rdata <= s_mem[in_spk_addr_o];
    end

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill_u(input logic [U_W-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [BW-1:0] fill_w(input logic [W_W-1:0] v);
        return {LANES{v}};
    endfunction

    always @(negedge clk) begin
        if (!rst && u_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", LW'(u_we_o), LW'(1'b0));
            end else begin
                chk({exp_q[0].nm, "_u"}, u_wdata_o, exp_q[0].u);
                chk({exp_q[0].nm, "_spk"}, LW'(spk_wdata_o), LW'(exp_q[0].s));
                chk({exp_q[0].nm, "_spk_we"}, LW'(spk_we_o), LW'(1'b1));
                chk({exp_q[0].nm, "_u_addr"}, LW'(u_addr_o), LW'(exp_q[0].tile));
                chk({exp_q[0].nm, "_spk_addr"}, LW'(spk_addr_o), LW'(exp_q[0].tile));
            end
        end
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", LW'(done_o), LW'(1'b0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, "_latency"}, LW'(cyc - e.t0), LW'(e.lat));
                chk({e.nm, "_we_single"}, LW'(u_we_o), LW'(1'b0));
            end
        end
    end

    task automatic run_case(input string nm, input logic [ADDR_W-1:0] tile,
                            input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] nin,
                            input logic [U_W-1:0] th, input logic [LW-1:0] eu,
                            input logic [LANES-1:0] es, input int lat, input bit disturb);
        exp_t e;
        tile_sel   = tile;
        w_row_base = base;
        cfg_n_in   = nin;
        cfg_thresh = th;
        start      = 1'b1;
        e.nm = nm; e.u = eu; e.s = es; e.tile = tile; e.lat = lat + LEAK_CYC; e.t0 = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            tile_sel   = 9'd400;
            w_row_base = 9'd0;
            cfg_n_in   = 13'd0;
            cfg_thresh = 16'hFF00;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        if (!done_o) begin
            chk({nm, "_timeout"}, LW'(done_o), LW'(1'b1));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [LW-1:0]    eu;
        logic [LANES-1:0] es;
        for (int a = 0; a < 2**ADDR_W; a++) begin
            u_mem[a] = '0; b_mem[a] = '0; w_mem[a] = '0; s_mem[a] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", LW'(busy_o), LW'(1'b0));
        chk("rst_done", LW'(done_o), LW'(1'b0));
        chk("rst_we", LW'({u_we_o, spk_we_o}), LW'(2'b00));
        chk("rst_addr", LW'({in_spk_addr_o, w_addr_o, b_addr_o, u_addr_o, spk_addr_o}), LW'(1'b0));
        chk("rst_u", u_wdata_o, LW'(1'b0));
        chk("rst_spk", LW'(spk_wdata_o), LW'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        // 105 >= 100 on every lane: all fire and reset to zero.
        u_mem[1] = fill_u(16'd100); b_mem[1] = fill_w(8'd5);
        run_case("nin0_fire", 9'd1, 9'd0, 13'd0, 16'd100, '0, 16'hFFFF, 5, 1'b0);

        // Bits 0 and 2 set: rows 32 and 34 add 10 each -> 20, below 50.
        s_mem[0] = 16'h0005; u_mem[3] = '0; b_mem[3] = '0;
        w_mem[32] = fill_w(8'd10); w_mem[33] = fill_w(8'h7F); w_mem[34] = fill_w(8'd10);
        run_case("two_spikes", 9'd3, 9'd32, 13'd16, 16'd50, fill_u(16'd20), 16'h0000, 11, 1'b0);

        // Positive saturation to 32767 then fire; bit 1 is beyond cfg_n_in=1.
        s_mem[0] = 16'h0003; u_mem[5] = fill_u(16'h7FF8); b_mem[5] = '0;
        w_mem[100] = fill_w(8'd20); w_mem[101] = fill_w(8'h80);
        run_case("sat_pos", 9'd5, 9'd100, 13'd1, 16'h7FFF, '0, 16'hFFFF, 9, 1'b0);

        // Negative saturation to -32768, no fire at threshold 0.
        s_mem[0] = 16'h0001; u_mem[6] = fill_u(16'h8008); b_mem[6] = '0;
        w_mem[110] = fill_w(8'hEC);
        run_case("sat_neg", 9'd6, 9'd110, 13'd0001, 16'd0, fill_u(16'h8000), 16'h0000, 9, 1'b0);

        // Partial second word; lane-distinct values; start/inputs disturbed while busy.
        s_mem[0] = 16'h0000; s_mem[1] = 16'hFFFF;
        for (int r = 200; r < 232; r++) w_mem[r] = fill_w((r < 216) ? 8'd50 : 8'd100);
        w_mem[216] = fill_w(8'd1); w_mem[217] = fill_w(8'd2); w_mem[218] = fill_w(8'd3);
        for (int k = 0; k < LANES; k++) begin
            w_mem[219][k*W_W +: W_W] = W_W'(k);
            u_mem[7][k*U_W +: U_W]   = U_W'(100 * k - 800);
            b_mem[7][k*W_W +: W_W]   = W_W'(k - 8);
        end
        eu = '0; es = '0;
        for (int k = 0; k < LANES; k++) begin
            if (102 * k - 802 >= 500) es[k] = 1'b1;
            else eu[k*U_W +: U_W] = U_W'(102 * k - 802);
        end
        run_case("partial_word", 9'd7, 9'd200, 13'd20, 16'd500, eu, es, 17, 1'b1);

        // Reset during accumulation: abort with no writeback.
        s_mem[0] = 16'hFFFF; u_mem[8] = fill_u(16'd1000);
        for (int r = 300; r < 316; r++) w_mem[r] = fill_w(8'd1);
        tile_sel = 9'd8; w_row_base = 9'd300; cfg_n_in = 13'd16; cfg_thresh = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_busy", LW'(busy_o), LW'(1'b1));
        rst = 1'b1;
        #1;
        chk("abort_busy", LW'(busy_o), LW'(1'b0));
        chk("abort_we", LW'({u_we_o, spk_we_o, done_o}), LW'(3'b000));
        chk("abort_u", u_wdata_o, LW'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle", LW'(busy_o), LW'(1'b0));

        u_mem[9] = fill_u(16'd100); b_mem[9] = fill_w(8'd5);
        run_case("after_abort", 9'd9, 9'd0, 13'd0, 16'd100, '0, 16'hFFFF, 5, 1'b0);

        // 160 with leak shift 4 becomes 150; without leak it stays 160.
        u_mem[10] = fill_u(16'd160); b_mem[10] = '0;
`ifdef SNN_LEAK_EN
        run_case("leak", 9'd10, 9'd0, 13'd0, 16'd1000, fill_u(16'd150), 16'h0000, 5, 1'b0);
`else
        run_case("no_leak", 9'd10, 9'd0, 13'd0, 16'd1000, fill_u(16'd160), 16'h0000, 5, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", LW'(exp_q.size()), LW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
